// File: rtl/sec_timer_ctrl.sv
// Countdown seconds timer with a private mclk prescaler that only runs in RUN.
// Optional periodic mode on expiry: define SEC_TIMER_AUTO_RELOAD_EN.
module sec_timer_ctrl #(
  parameter int CUENTA = 50_000_000,
  parameter int CNT_W  = 16
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic             tick_1hz,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int            PW       = (CUENTA > 1) ? $clog2(CUENTA) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(CUENTA - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           st, st_n;
  logic [PW-1:0]    psc, psc_n;
  logic [CNT_W-1:0] reload, reload_n, rem_n;
  logic             tick_n, done_n;
  logic             wrap;
  logic             expire_reload;

  assign wrap  = (psc == PSC_LAST);
  assign state = st;

`ifdef SEC_TIMER_AUTO_RELOAD_EN
  assign expire_reload = (reload != '0);
`else
  assign expire_reload = 1'b0;
`endif

  // Priority: clear > load > start > pause (reset handled in the register).
  always_comb begin
    st_n     = st;
    psc_n    = psc;
    rem_n    = remaining;
    reload_n = reload;
    tick_n   = 1'b0;
    done_n   = 1'b0;
    if (clear) begin
      st_n  = S_IDLE;
      psc_n = '0;
      rem_n = reload;
    end else begin
      case (st)
        S_IDLE: begin
          if (load) begin
            rem_n    = load_val;
            reload_n = load_val;
            psc_n    = '0;
          end else if (start) begin
            psc_n = '0;
            if (remaining != '0) begin
              st_n = S_RUN;
            end else begin
              st_n   = S_DONE;
              done_n = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (wrap) begin
            psc_n  = '0;
            tick_n = 1'b1;
            if (remaining > CNT_W'(1)) begin
              rem_n = remaining - 1'b1;
              if (pause) st_n = S_PAUSE;
            end else if (expire_reload) begin
              // Periodic mode: prescaler keeps running straight into the next period.
              rem_n  = reload;
              done_n = 1'b1;
              if (pause) st_n = S_PAUSE;
            end else begin
              rem_n  = '0;
              done_n = 1'b1;
              st_n   = S_DONE;
            end
          end else begin
            psc_n = psc + 1'b1;
            if (pause) st_n = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!load && start) st_n = S_RUN;
        end
        S_DONE: begin
          if (load) begin
            rem_n    = load_val;
            reload_n = load_val;
            psc_n    = '0;
            st_n     = S_IDLE;
          end else if (start) begin
            psc_n = '0;
            rem_n = reload;
            if (reload != '0) begin
              st_n = S_RUN;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      st        <= S_IDLE;
      psc       <= '0;
      remaining <= '0;
      reload    <= '0;
      tick_1hz  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      st        <= st_n;
      psc       <= psc_n;
      remaining <= rem_n;
      reload    <= reload_n;
      tick_1hz  <= tick_n;
      done      <= done_n;
      busy      <= (st_n == S_RUN) || (st_n == S_PAUSE);
    end
  end

endmodule

// File: tb/tb_sec_timer_ctrl.sv
// Directed bench for sec_timer_ctrl with CUENTA=4; expectations are hand-derived.
module tb_sec_timer_ctrl;

  localparam int CNT_W = 16;

  logic             mclk = 1'b0;
  logic             reset = 1'b1;
  logic             load = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             clear = 1'b0;
  logic             tick_1hz;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;

  sec_timer_ctrl #(.CUENTA(4), .CNT_W(CNT_W)) dut (
    .mclk(mclk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .clear(clear), .tick_1hz(tick_1hz),
    .remaining(remaining), .busy(busy), .done(done), .state(state)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_st, input int e_rem,
                         input logic e_busy, input logic e_tick, input logic e_done);
    chk({tag, ".state"}, 32'(state), 32'(e_st));
    chk({tag, ".remaining"}, 32'(remaining), 32'(e_rem));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".tick"}, 32'(tick_1hz), 32'(e_tick));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  task automatic do_load(input logic [CNT_W-1:0] v);
    load = 1'b1; load_val = v; step(); load = 1'b0;
  endtask
  task automatic do_start(); start = 1'b1; step(); start = 1'b0; endtask
  task automatic do_pause(); pause = 1'b1; step(); pause = 1'b0; endtask
  task automatic do_clear(); clear = 1'b1; step(); clear = 1'b0; endtask

  initial begin
    // Reset state
    #1; step(); step();
    chk_all("reset", IDLE, 0, 0, 0, 0);
    reset = 1'b0;

    // Basic countdown from 3: ticks at 4, 8, 12 after start, done at 12
    do_load(3);
    chk_all("load3", IDLE, 3, 0, 0, 0);
    do_start();
    chk_all("start3", RUN, 3, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_all($sformatf("cnt3.c%0d", i), (i == 12) ? DONE : RUN, 3 - i / 4,
              (i < 12), (i % 4 == 0), (i == 12));
    end
    step();
    chk_all("cnt3.after", DONE, 0, 0, 0, 0);

    // Pause at cycle 6, hold 20, resume: next tick 2 cycles after resume
    do_load(5);
    chk_all("load5", IDLE, 5, 0, 0, 0);
    do_start();
    for (int i = 1; i <= 5; i++) step();
    chk("p5.rem_c5", 32'(remaining), 32'd4);
    do_pause();
    chk_all("p5.paused", PAUSE, 4, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_all($sformatf("p5.hold%0d", i), PAUSE, 4, 1, 0, 0);
    end
    do_start();
    chk_all("p5.resume", RUN, 4, 1, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      step();
      chk_all($sformatf("p5.r%0d", i), (i == 14) ? DONE : RUN, 4 - (i + 2) / 4,
              (i < 14), (i % 4 == 2), (i == 14));
    end

    // Clear from DONE restores reload; zero load then start expires at once
    do_clear();
    chk_all("clr.done", IDLE, 5, 0, 0, 0);
    do_load(0);
    chk_all("load0", IDLE, 0, 0, 0, 0);
    do_start();
    chk_all("start0", DONE, 0, 0, 0, 1);
    step();
    chk_all("start0.after", DONE, 0, 0, 0, 0);
    do_start();
    chk_all("restart0", DONE, 0, 0, 0, 1);
    step();
    chk_all("restart0.after", DONE, 0, 0, 0, 0);

    // Clear on the tick edge: no tick, no decrement
    do_load(3);
    chk_all("load3b", IDLE, 3, 0, 0, 0);
    do_start();
    for (int i = 1; i <= 3; i++) step();
    do_clear();
    chk_all("clr.tick", IDLE, 3, 0, 0, 0);
    step();
    chk_all("clr.tick.after", IDLE, 3, 0, 0, 0);

    // Pause on the tick edge: tick and decrement happen, then PAUSE
    do_start();
    for (int i = 1; i <= 3; i++) step();
    do_pause();
    chk_all("pause.tick", PAUSE, 2, 1, 1, 0);
    step();
    chk_all("pause.tick.after", PAUSE, 2, 1, 0, 0);
    do_clear();
    chk_all("clr.pause", IDLE, 3, 0, 0, 0);

    // Load and start ignored in RUN; reset mid-RUN clears everything
    do_start();
    for (int i = 1; i <= 4; i++) step();
    chk_all("run.rem2", RUN, 2, 1, 1, 0);
    do_load(7);
    chk_all("run.load_ign", RUN, 2, 1, 0, 0);
    do_start();
    chk_all("run.start_nop", RUN, 2, 1, 0, 0);
    step();
    chk_all("run.c7", RUN, 2, 1, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("midrst", IDLE, 0, 0, 0, 0);
    do_start();
    chk_all("midrst.start", DONE, 0, 0, 0, 1);
    do_clear();
    chk_all("midrst.clr", IDLE, 0, 0, 0, 0);

    // Expiry with load 2
    do_load(2);
    do_start();
    chk_all("ar.start", RUN, 2, 1, 0, 0);
`ifdef SEC_TIMER_AUTO_RELOAD_EN
    for (int i = 1; i <= 25; i++) begin
      step();
      chk_all($sformatf("ar.c%0d", i), RUN, 2 - ((i / 4) % 2), 1,
              (i % 4 == 0), (i % 8 == 0));
    end
`else
    for (int i = 1; i <= 9; i++) begin
      step();
      chk_all($sformatf("nar.c%0d", i), (i >= 8) ? DONE : RUN, (i >= 8) ? 0 : 2 - i / 4,
              (i < 8), (i == 4 || i == 8), (i == 8));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
